// File: rtl/mul_sequencer.sv
// Job sequencer for a repeated-add multiplier core: queues operand pairs,
// re-arms and starts the core per job, and returns product or timeout error.
module mul_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 70000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             core_rst,
  output logic             start,
  output logic [WIDTH-1:0] data_in,
  input  logic             core_ldA,
  input  logic             core_ldB,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_p,
  output logic             res_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]       state, state_nx;
  logic [WIDTH-1:0] fifo_a [2];
  logic [WIDTH-1:0] fifo_b [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_nx;
  logic             push, pop;
  logic [WIDTH-1:0] a_reg, b_reg, a_nx, b_nx;
  logic [WIDTH-1:0] p_nx;
  logic             err_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             last_cycle;

  assign push      = op_valid && op_ready;
  assign count_nx  = count + 2'(push) - 2'(pop);
  assign last_cycle = (cnt == CW'(TIMEOUT - 1));

  // Shared operand bus: B only while the core is loading its multiplier.
  assign data_in = core_ldB ? b_reg : a_reg;

  // Next-state, FIFO pop and result selection.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    a_nx     = a_reg;
    b_nx     = b_reg;
    p_nx     = res_p;
    err_nx   = res_err;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          pop  = 1'b1;
          a_nx = fifo_a[rd_ptr];
          b_nx = fifo_b[rd_ptr];
          if (a_nx == '0 || b_nx == '0) begin
            // Zero operand: answer is known, the core is never touched.
            state_nx = HOLD;
            p_nx     = '0;
            err_nx   = 1'b0;
          end else begin
            state_nx = ARM;
          end
        end
      end
      ARM: begin
        cnt_nx   = '0;
        state_nx = START;
      end
      START: begin
        cnt_nx = cnt + CW'(1);
        if (last_cycle) begin
          state_nx = HOLD;
          p_nx     = '0;
          err_nx   = 1'b1;
        end else if (core_ldA) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        cnt_nx = cnt + CW'(1);
        if (core_done) begin
          state_nx = HOLD;
          p_nx     = core_p;
          err_nx   = 1'b0;
        end else if (last_cycle) begin
          state_nx = HOLD;
          p_nx     = '0;
          err_nx   = 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, control and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      op_ready  <= 1'b1;
      a_reg     <= '0;
      b_reg     <= '0;
      res_p     <= '0;
      res_err   <= 1'b0;
      cnt       <= '0;
      core_rst  <= 1'b0;
      start     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      op_ready  <= (count_nx < 2'd2);
      a_reg     <= a_nx;
      b_reg     <= b_nx;
      res_p     <= p_nx;
      res_err   <= err_nx;
      cnt       <= cnt_nx;
      core_rst  <= (state_nx == ARM);
      start     <= (state_nx == START);
      res_valid <= (state_nx == HOLD);
    end
  end

  // Operand storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= op_a;
      fifo_b[wr_ptr] <= op_b;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized bench for mul_sequencer with a behavioural repeated-add core
// and a queue-based reference model of expected results.
module tb_mul_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 400;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         core_rst, start;
  logic [W-1:0] data_in;
  logic         core_ldA, core_ldB, core_done;
  logic [W-1:0] core_p;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_p;
  logic         res_err;

  mul_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .core_rst(core_rst), .start(start), .data_in(data_in),
    .core_ldA(core_ldA), .core_ldB(core_ldB), .core_done(core_done), .core_p(core_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Core model: start -> load A -> load B -> one add per cycle -> sticky done.
  int           cs = 0;
  logic [W-1:0] ca = '0, cb = '0, cp = '0;
  logic         stuck_done = 1'b0;

  always @(posedge clk) begin
    if (core_rst) begin
      cs <= 0;
      cp <= '0;
    end else begin
      case (cs)
        0: if (start) cs <= 1;
        1: begin ca <= data_in; cs <= 2; end
        2: begin cb <= data_in; cp <= '0; cs <= 3; end
        3: begin
          cp <= cp + ca;
          cb <= cb - 16'd1;
          if (cb == 16'd1) cs <= 4;
        end
        default: ;
      endcase
    end
  end

  assign core_ldA  = (cs == 1);
  assign core_ldB  = (cs == 2);
  assign core_p    = cp;
  assign core_done = stuck_done ? 1'b0 : (cs == 4);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         terr;
  } job_t;

  job_t         q[$];
  job_t         j;
  logic [31:0]  prod;
  logic [W-1:0] exp_p;
  int           cyc = 0;
  int           arm_cnt = 0, start_cnt = 0, nz_cnt = 0, res_cnt = 0;
  int           arm_cyc = 0, gap = 0;
  logic         armed = 1'b0, saw_not_ready = 1'b0;
  logic         prev_start = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  logic [W-1:0] prev_p = '0, last_p = '0;
  logic         last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model bookkeeping and protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      armed      = 1'b0;
      prev_start = 1'b0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (!op_ready) saw_not_ready = 1'b1;
      if (op_valid && op_ready) begin
        j.a = op_a;
        j.b = op_b;
        j.terr = stuck_done && op_a != '0 && op_b != '0;
        q.push_back(j);
        if (op_a != '0 && op_b != '0) nz_cnt++;
      end
      if (core_rst) begin
        arm_cnt++;
        armed   = 1'b1;
        arm_cyc = cyc;
      end
      if (start) start_cnt++;
      if (start && !prev_start) begin
        check("arm_before_start", 32'(armed), 32'd1);
        armed = 1'b0;
      end
      if (core_ldA) begin
        if (q.size() == 0) check("ldA_no_job", 32'd1, 32'd0);
        else check("data_in_ldA", 32'(data_in), 32'(q[0].a));
      end
      if (core_ldB) begin
        if (q.size() == 0) check("ldB_no_job", 32'd1, 32'd0);
        else check("data_in_ldB", 32'(data_in), 32'(q[0].b));
      end
      if (res_valid && !prev_valid) gap = cyc - arm_cyc;
      if (res_valid && prev_valid && !prev_hs) begin
        check("hold_p_stable", 32'(res_p), 32'(prev_p));
        check("hold_err_stable", 32'(res_err), 32'(prev_err));
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          j     = q.pop_front();
          prod  = 32'(j.a) * 32'(j.b);
          exp_p = j.terr ? '0 : prod[W-1:0];
          check("res_p", 32'(res_p), 32'(exp_p));
          check("res_err", 32'(res_err), 32'(j.terr));
        end
        res_cnt++;
        last_p   = res_p;
        last_err = res_err;
      end
      prev_start = start;
      prev_valid = res_valid;
      prev_hs    = res_valid && res_ready;
      prev_p     = res_p;
      prev_err   = res_err;
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int i;
    @(posedge clk); #1;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!op_ready && i < 1000);
    if (!op_ready) check("push_accept", 32'd0, 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    res_ready = 1'b1;
    i = 0;
    while ((q.size() != 0 || res_valid) && i < 3000) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  int   a0, s0, r0, n0;
  logic hs;

  initial begin
    #1 rst = 1'b1;
    #22;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_p", 32'(res_p), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic multiply with core arm/start.
    res_ready = 1'b1;
    a0 = arm_cnt; s0 = start_cnt;
    push(16'd7, 16'd5);
    drain();
    check("t1_arm_cycles", 32'(arm_cnt - a0), 32'd1);
    check("t1_started", 32'(start_cnt != s0), 32'd1);
    check("t1_p", 32'(last_p), 32'd35);
    check("t1_err", 32'(last_err), 32'd0);

    // Zero bypass leaves the core alone.
    a0 = arm_cnt; s0 = start_cnt; r0 = res_cnt;
    push(16'd0, 16'd9);
    push(16'd9, 16'd0);
    drain();
    check("t2_results", 32'(res_cnt - r0), 32'd2);
    check("t2_no_arm", 32'(arm_cnt - a0), 32'd0);
    check("t2_no_start", 32'(start_cnt - s0), 32'd0);
    check("t2_p", 32'(last_p), 32'd0);

    // Truncation of the product.
    push(16'd300, 16'd300);
    drain();
    check("t3_p", 32'(last_p), 32'd24464);

    // Back-pressure with FIFO filling behind a held result.
    res_ready = 1'b0;
    saw_not_ready = 1'b0;
    r0 = res_cnt;
    push(16'd1, 16'd1);
    push(16'd1, 16'd2);
    push(16'd1, 16'd3);
    for (int i = 0; i < 500 && !res_valid; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("t4_held_valid", 32'(res_valid), 32'd1);
    check("t4_held_p", 32'(res_p), 32'd1);
    check("t4_op_ready_fell", 32'(saw_not_ready), 32'd1);
    drain();
    check("t4_results", 32'(res_cnt - r0), 32'd3);
    check("t4_last_p", 32'(last_p), 32'd3);

    // Timeout with a core that never finishes.
    stuck_done = 1'b1;
    push(16'd5, 16'd7);
    drain();
    check("t5_gap", 32'(gap), 32'(TO + 1));
    check("t5_err", 32'(last_err), 32'd1);
    check("t5_p", 32'(last_p), 32'd0);
    stuck_done = 1'b0;
    push(16'd2, 16'd3);
    drain();
    check("t5_next_p", 32'(last_p), 32'd6);
    check("t5_next_err", 32'(last_err), 32'd0);

    // Reset in the middle of a running job with a pair queued.
    res_ready = 1'b1;
    push(16'd3, 16'd100);
    push(16'd1, 16'd1);
    for (int i = 0; i < 200 && cs != 3; i++) @(posedge clk);
    check("t6_reached_run", 32'(cs == 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_op_ready", 32'(op_ready), 32'd1);
    check("t6_start", 32'(start), 32'd0);
    check("t6_core_rst", 32'(core_rst), 32'd0);
    check("t6_res_valid", 32'(res_valid), 32'd0);
    check("t6_res_p", 32'(res_p), 32'd0);
    check("t6_res_err", 32'(res_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r0 = res_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("t6_queue_flushed", 32'(res_cnt - r0), 32'd0);
    check("t6_idle_valid", 32'(res_valid), 32'd0);
    push(16'd4, 16'd4);
    drain();
    check("t6_p", 32'(last_p), 32'd16);

    // Randomized traffic with random back-pressure.
    a0 = arm_cnt; n0 = nz_cnt;
    op_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      hs = op_valid && op_ready;
      @(posedge clk); #1;
      res_ready = ($urandom_range(0, 3) != 0);
      if (hs || !op_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          op_valid = 1'b0;
        end else begin
          op_valid = 1'b1;
          op_a = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
          op_b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
        end
      end
    end
    op_valid = 1'b0;
    drain();
    check("rand_arm_per_job", 32'(arm_cnt - a0), 32'(nz_cnt - n0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
